spi_sensor_responder: RTL

// - SPI slave (mode 0: CPOL=0, CPHA=0, MSB first) playing the sensor end of the SPI link the sensor sequencer drives.
// - Latches a parallel sample when chip-select falls and shifts it out on MISO.
// - Captures MOSI bits into a receive word. Used for board-level loopback and for sensor emulation in simulation.

---
 rtl/spi_resp_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 43 ++++
 rtl/spi_sensor_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_resp_pkg
// Purpose  : Shared state type and SPI mode constants for the SPI sensor
//            responder slice.
// Revision : 1.0 - initial release
// ============================================================================
package spi_resp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } spi_resp_state_t;

   // SPI mode 0: sclk idles low, data sampled on the rising edge.
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Multi-flop synchronizer for an asynchronous input, followed by
//            single-cycle rise and fall pulses on the synchronized value.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_det #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   // Next value of the synchronizer chain and the one-cycle-old copy of its tail.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   // Chain registers; reset to the line's idle level so release causes no edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q[STAGES-1] & ~prev_q;
   assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_sensor_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_sensor_responder
// Purpose  : SPI mode-0 slave emulating a sensor. Latches data_i at frame
//            start and shifts it out MSB first on miso while capturing mosi
//            into a receive word presented on rx_data with an rx_valid pulse.
//            Optional macro SPI_RESP_FRAME_ERR_EN enables the frame_err pulse
//            on short or aborted frames; otherwise frame_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_sensor_responder
   import spi_resp_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              frame_err
);

   localparam int               CNT_W   = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W);

   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

   spi_resp_state_t   state_q, state_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              miso_q, miso_d;
   logic              miso_oe_q, miso_oe_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_det (
      .clk  (clk),
      .rst  (rst),
      .d    (sclk),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_det (
      .clk  (clk),
      .rst  (rst),
      .d    (cs_n),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // mosi gets the same delay as sclk so the sampled bit lines up with the rise pulse.
   always_comb begin
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
   end
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // Frame sequencing, shift registers and output staging.
   always_comb begin
      state_d    = state_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      bit_cnt_d  = bit_cnt_q;
      miso_d     = miso_q;
      miso_oe_d  = miso_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) state_d = LOAD;
         end
         LOAD: begin
            tx_sh_d   = data_i;
            miso_d    = data_i[DATA_W-1];
            rx_sh_d   = '0;
            bit_cnt_d = '0;
            miso_oe_d = 1'b1;
            state_d   = SHIFT;
         end
         SHIFT: begin
            // A deselect wins over any sclk edge seen in the same cycle.
            if (cs_rise) begin
               state_d = DONE;
            end else begin
               if (sclk_rise && (bit_cnt_q != CNT_MAX)) begin
                  rx_sh_d   = {rx_sh_q[DATA_W-2:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
               if (sclk_fall) begin
                  tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                  miso_d  = tx_sh_q[DATA_W-2];
               end
            end
         end
         DONE: begin
            if (bit_cnt_q == CNT_MAX) begin
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
            end
            miso_oe_d = 1'b0;
            miso_d    = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mosi_sync_q <= '0;
         state_q     <= IDLE;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         bit_cnt_q   <= '0;
         miso_q      <= 1'b0;
         miso_oe_q   <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
      end else begin
         mosi_sync_q <= mosi_sync_d;
         state_q     <= state_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         bit_cnt_q   <= bit_cnt_d;
         miso_q      <= miso_d;
         miso_oe_q   <= miso_oe_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
      end
   end

`ifdef SPI_RESP_FRAME_ERR_EN
   logic frame_err_q, frame_err_d;

   // Flag a frame that ended before a full word was clocked in.
   always_comb begin
      frame_err_d = (state_q == DONE) && (bit_cnt_q != CNT_MAX);
   end

   // Register the error flag so it lines up with rx_valid timing.
   always_ff @(posedge clk) begin
      if (!rst) frame_err_q <= 1'b0;
      else      frame_err_q <= frame_err_d;
   end

   assign frame_err = frame_err_q;
`else
   assign frame_err = 1'b0;
`endif

   assign miso     = miso_q;
   assign miso_oe  = miso_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire
